interval_timer: RTL
===================

# interval_timer

Programmable down-counting interval timer driven by the 1 MHz divided clock. It samples `clk_1mhz` in the system clock domain, turns each rising edge into a single-cycle microsecond tick, and optionally prescales that tick. It counts a 16-bit register down to zero and raises a maskable interrupt on expiry. It sits directly downstream of the clock divider and is mapped as a 4-register peripheral on the CPU bus.

## Interface
- `WIDTH`, 16, width of LOAD/COUNT registers and of the bus data path.
- `clk`  in  1  system clock (16 MHz); sole clock of the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_1mhz`  in  1  divided clock, registered in the `clk` domain; used as a data input only, never as a clock.
- `addr`  in  2  register select: 0 CTRL, 1 LOAD, 2 COUNT, 3 PRESCALE.
- `wdata`  in  WIDTH  write data.
- `we`  in  1  write strobe; one write per cycle it is high.
- `rdata`  out  WIDTH  combinational read of the register selected by `addr`; unused bits read 0.
- `irq`  out  1  interrupt request, equal to IRQ_FLAG & IRQ_EN.

## Operation
- CTRL register:
  - bit0 EN.
  - bit1 AUTO (auto-reload).
  - bit2 IRQ_EN.
  - bit3 IRQ_FLAG: writing 1 clears it, writing 0 has no effect.
  - Bits 15:4 read 0.
- Edge detect: `clk_1mhz_q` is `clk_1mhz` delayed one `clk`. The tick is `clk_1mhz & ~clk_1mhz_q`, exactly one `clk` wide, once per microsecond.
- Prescaler: an 8-bit `pre_cnt` compared with `PRESCALE[7:0]`.
  - On a tick with EN=1: if `pre_cnt == PRESCALE`, then `pre_cnt` is set to 0 and a step is issued; otherwise `pre_cnt` increments.
  - The step period is therefore (PRESCALE+1) µs.
- Step behaviour:
  - If COUNT != 0: COUNT decrements by 1.
  - If COUNT == 0: IRQ_FLAG is set.
    - AUTO=1: COUNT is loaded from LOAD.
    - AUTO=0: EN clears (one-shot) and COUNT stays 0.
- Expiry period from a fresh load is (LOAD+1) steps. With LOAD=0 and AUTO=1, the timer expires on every step.
- While EN=0, the tick is ignored and `pre_cnt` and COUNT hold.
- A write of EN from 0 to 1 clears `pre_cnt` in the same edge.
- A write to LOAD does not alter COUNT; it takes effect at the next reload.
- Arithmetic is unsigned and modulo 2^WIDTH. No step occurs from COUNT=0 other than expiry, so there is no underflow wrap.

## Timing
- Reset (`rst_n` low, async): CTRL, LOAD, COUNT, PRESCALE, `pre_cnt`, and `clk_1mhz_q` are all 0. Consequently `irq`=0 and `rdata`=0 for every address.
- Reset is fully honoured mid-count; there is no recovery state.
- Latency:
  - `clk_1mhz` goes high after edge N, so the tick is high in cycle N.
  - COUNT and `pre_cnt` update at edge N+1.
  - IRQ_FLAG sets at the same edge as the expiring step.
  - `irq` follows combinationally in the same cycle.
- Writes take effect at the `clk` edge where `we`=1. `rdata` reflects the new value from the next cycle.
- Simultaneous events:
  - CPU write to COUNT and a step in the same cycle: the write wins and the step is lost.
  - IRQ_FLAG clear and expiry in the same cycle: the set wins and the flag remains 1.
  - CTRL write with EN=0 and a step in the same cycle: the write wins and no decrement occurs.
  - CTRL write that keeps EN=1 and a step in the same cycle: the step proceeds.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - PRESCALE register and `pre_cnt` are implemented as described above.
- Not defined:
  - Address 3 reads 0 and writes to it are ignored.
  - `pre_cnt` is absent.
  - Every enabled tick is a step, i.e. a 1 µs step period.

## Test plan
- Reset: assert `rst_n`=0 mid-count with COUNT=0x0123 → all reads return 0 and `irq`=0 immediately, without waiting for a `clk` edge.
- One-shot: LOAD irrelevant, COUNT=3, CTRL=0x5 (EN, IRQ_EN), PRESCALE=0 → COUNT reads 2, 1, 0 at 1 µs intervals. `irq` rises at the 4th tick (+1 clk) and EN reads 0. No further activity for 10 µs.
- Auto-reload: LOAD=4, COUNT=0, CTRL=0x7 → `irq` flags every 5 µs. Writing CTRL=0xF clears the flag, and it re-sets 5 µs later.
- Prescale (macro defined): PRESCALE=15, COUNT=1, CTRL=0x5 → COUNT=0 after 16 µs and `irq` after 32 µs. Without the macro, the same writes give 1 µs and 2 µs, and address 3 reads 0.
- Collision: with COUNT=5, write COUNT=0x0100 in the exact cycle a tick is high → COUNT reads 0x0100, not 0x00FF or 4.
- Flag race: issue a CTRL write with bit3=1 in the expiry cycle → IRQ_FLAG reads 1 afterwards and `irq` stays high.

Source files
------------

// File: rtl/interval_timer.sv
// Programmable 16-bit down-counting interval timer with a maskable expiry interrupt.
// Optional prescaler (PRESCALE register + pre_cnt) is built when TIMER_PRESCALE_EN is defined.
`timescale 1ns/1ps
module interval_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_1mhz,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             we,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_LOAD     = 2'd1;
  localparam logic [1:0] ADDR_COUNT    = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  logic             r_clk_q;
  logic             r_en;
  logic             r_auto;
  logic             r_irq_en;
  logic             r_flag;
  logic [WIDTH-1:0] r_load;
  logic [WIDTH-1:0] r_count;

  logic w_tick;
  logic w_wr_ctrl;
  logic w_wr_load;
  logic w_wr_count;
  logic w_active;
  logic w_step;
  logic w_expire;

  assign w_tick     = clk_1mhz & ~r_clk_q;
  assign w_wr_ctrl  = we && (addr == ADDR_CTRL);
  assign w_wr_load  = we && (addr == ADDR_LOAD);
  assign w_wr_count = we && (addr == ADDR_COUNT);
  // A CTRL write that drops EN suppresses the tick in the same cycle.
  assign w_active   = w_tick & r_en & ~(w_wr_ctrl & ~wdata[0]);
  assign w_expire   = w_step && (r_count == '0);

`ifdef TIMER_PRESCALE_EN
  logic       w_wr_pre;
  logic [7:0] r_prescale;
  logic [7:0] r_pre_cnt;

  assign w_wr_pre = we && (addr == ADDR_PRESCALE);
  assign w_step   = w_active && (r_pre_cnt == r_prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_pre_cnt  <= '0;
    end else begin
      if (w_wr_pre) r_prescale <= wdata[7:0];
      if (w_wr_ctrl && wdata[0] && !r_en) begin
        r_pre_cnt <= '0;
      end else if (w_active) begin
        if (r_pre_cnt == r_prescale) r_pre_cnt <= '0;
        else                         r_pre_cnt <= r_pre_cnt + 8'd1;
      end
    end
  end
`else
  assign w_step = w_active;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_q  <= 1'b0;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_irq_en <= 1'b0;
      r_flag   <= 1'b0;
      r_load   <= '0;
      r_count  <= '0;
    end else begin
      r_clk_q <= clk_1mhz;
      if (w_wr_ctrl) begin
        r_en     <= wdata[0];
        r_auto   <= wdata[1];
        r_irq_en <= wdata[2];
        if (wdata[3]) r_flag <= 1'b0;
      end
      // Expiry is ordered after the CTRL write so a same-cycle flag clear loses.
      if (w_step) begin
        if (!w_expire) begin
          r_count <= r_count - WIDTH'(1);
        end else begin
          r_flag <= 1'b1;
          if (r_auto) r_count <= r_load;
          else        r_en    <= 1'b0;
        end
      end
      if (w_wr_load)  r_load  <= wdata;
      if (w_wr_count) r_count <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:     rdata = {{(WIDTH-4){1'b0}}, r_flag, r_irq_en, r_auto, r_en};
      ADDR_LOAD:     rdata = r_load;
      ADDR_COUNT:    rdata = r_count;
`ifdef TIMER_PRESCALE_EN
      ADDR_PRESCALE: rdata = {{(WIDTH-8){1'b0}}, r_prescale};
`else
      ADDR_PRESCALE: rdata = '0;
`endif
      default:       rdata = '0;
    endcase
  end

  assign irq = r_flag & r_irq_en;

endmodule
